sa_host_ctrl: RTL and testbench
===============================

// Module: sa_host_ctrl
// PURPOSE
//  Host-side controller for the systolic-array subsystem FIFOs. It streams M operand words from an upstream
//  valid/ready source into the subsystem input FIFO (din/wr_fifo/in_fifo_full), then drains M result
//  words from the subsystem output FIFO (dout/rd_fifo/out_fifo_empty) to a downstream valid/ready sink.
//  It sits between the host fabric and the subsystem, on the sys_clk domain.
// PARAMETERS
//  DIN_WIDTH  8   operand element width (bits)
//  N          4   array dimension; BUS_WIDTH = 2*DIN_WIDTH*N (localparam, 64 at defaults)
// PORTS
//  sys_clk         in   1          system clock, all logic rising-edge
//  rst             in   1          asynchronous, active-high reset
//  start           in   1          begin a job; sampled only in IDLE
//  m_minus_one     in   8          job length minus one (M = m_minus_one+1, 1..256); captured on start
//  busy            out  1          high from accepted start until DONE exits
//  done            out  1          one-cycle pulse when last result accepted downstream
//  s_data          in   BUS_WIDTH  upstream operand word
//  s_valid         in   1          upstream word valid
//  s_ready         out  1          controller accepts s_data this cycle
//  din             out  BUS_WIDTH  to subsystem input FIFO
//  wr_fifo         out  1          input FIFO write strobe
//  in_fifo_full    in   1          input FIFO full
//  rd_fifo         out  1          output FIFO read strobe
//  dout            in   BUS_WIDTH  output FIFO data, valid the cycle after rd_fifo
//  out_fifo_empty  in   1          output FIFO empty
//  m_data          out  BUS_WIDTH  downstream result word
//  m_valid         out  1          downstream word valid
//  m_ready         in   1          downstream accepts m_data
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, s_ready, wr_fifo, rd_fifo, m_valid = 0; din, m_data = 0; counters = 0.
//  FSM: IDLE -start-> LOAD -M words written-> DRAIN -M words accepted downstream-> DONE -1 cycle-> IDLE.
//  start outside IDLE is ignored (no queuing, no error). m_minus_one is captured into a job register at start.
//  LOAD: s_ready = !in_fifo_full (combinational). On s_valid&&s_ready: din<=s_data, wr_fifo<=1 next cycle
//   (registered, 1-cycle latency), in_cnt++. When in_cnt reaches M, s_ready drops the same cycle; go DRAIN.
//   wr_fifo is never asserted while in_fifo_full is high in the cycle of the handshake.
//  DRAIN: 2-entry result buffer + credit count. credits = 2 - occupancy - rd_inflight.
//   rd_fifo = !out_fifo_empty && credits>0 && rd_issued<M (combinational); rd_inflight set for 1 cycle.
//   The cycle after rd_fifo, dout is written into the buffer. m_valid = buffer non-empty; m_data = head.
//   Pop on m_valid&&m_ready; out_cnt++. Simultaneous push and pop on same cycle is legal, occupancy unchanged.
//   Full throughput: one word/cycle sustained when out_fifo_empty=0 and m_ready=1.
//   m_data/m_valid hold stable while m_valid && !m_ready (AXI-style stability).
//  DONE: done=1 for exactly one cycle, busy=0 entering IDLE next cycle. rd_issued never exceeds M.
//  Counters are 9 bits (M up to 256); no wrap within a job. M=1: one write, one read, then DONE.
//  Reset mid-job: immediately returns to IDLE, all strobes low, buffer discarded; FIFOs are not flushed.
// TESTING
//  1 Reset: assert rst mid-LOAD -> all outputs 0 async, state IDLE; next start runs clean job.
//  2 M=4, s_valid=1, full=0: din gets 4 words, wr_fifo high 4 consecutive cycles, s_ready low after 4th.
//  3 M=4 with in_fifo_full toggling 1010: wr_fifo never follows a handshake during full; 4 writes total, order kept.
//  4 DRAIN M=8, empty=0, m_ready=1: 8 rd_fifo in 8 cycles, m_data matches dout order, done pulse once.
//  5 DRAIN with m_ready low 3 cycles: rd_fifo stops after 2 credits, m_data stable, no word lost/duplicated.
//  6 m_minus_one=255 and =0: 256 and 1 words each way; start while busy ignored; done exactly one cycle.

Source files
------------

// File: rtl/sa_host_ctrl.sv
// Host-side job controller for the systolic-array subsystem: streams M operand words into the
// subsystem input FIFO, then drains M result words from the output FIFO to a valid/ready sink.
module sa_host_ctrl #(
    parameter int unsigned DIN_WIDTH = 8,
    parameter int unsigned N         = 4
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               m_minus_one,
    output logic                     busy,
    output logic                     done,
    input  logic [2*DIN_WIDTH*N-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [2*DIN_WIDTH*N-1:0] din,
    output logic                     wr_fifo,
    input  logic                     in_fifo_full,
    output logic                     rd_fifo,
    input  logic [2*DIN_WIDTH*N-1:0] dout,
    input  logic                     out_fifo_empty,
    output logic [2*DIN_WIDTH*N-1:0] m_data,
    output logic                     m_valid,
    input  logic                     m_ready
);
    localparam int unsigned BUS_WIDTH = 2 * DIN_WIDTH * N;
    localparam int unsigned JOB_WIDTH = 8;
    localparam int unsigned CNT_WIDTH = 9;
    localparam int unsigned OCC_WIDTH = 2;
    localparam int unsigned CRD_WIDTH = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [JOB_WIDTH-1:0]   job_q, job_d;
    logic [CNT_WIDTH-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_WIDTH-1:0]   rd_issued_q, rd_issued_d;
    logic [CNT_WIDTH-1:0]   out_cnt_q, out_cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   wr_fifo_q, wr_fifo_d;
    logic [BUS_WIDTH-1:0]   din_q, din_d;
    logic                   rd_inflight_q, rd_inflight_d;
    logic [BUS_WIDTH-1:0]   buf_q [2];
    logic [BUS_WIDTH-1:0]   buf_d [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [OCC_WIDTH-1:0]   occ_q, occ_d;

    logic                   s_hs;
    logic                   push;
    logic                   pop;
    logic                   credit_ok;
    logic                   last_in;
    logic                   last_out;

    // Handshakes and FIFO strobes
    assign s_ready   = (state_q == S_LOAD) && !in_fifo_full;
    assign s_hs      = s_valid && s_ready;
    assign m_valid   = (occ_q != '0);
    assign m_data    = buf_q[rd_ptr_q];
    assign pop       = m_valid && m_ready;
    assign push      = rd_inflight_q;
    assign last_in   = (in_cnt_q == CNT_WIDTH'(job_q));
    assign last_out  = (out_cnt_q == CNT_WIDTH'(job_q));
    // A pop this cycle frees its slot before a read issued now can land, sustaining one word per cycle.
    assign credit_ok = (CRD_WIDTH'(occ_q) + CRD_WIDTH'(rd_inflight_q)) < (CRD_WIDTH'(2) + CRD_WIDTH'(pop));
    assign rd_fifo   = (state_q == S_DRAIN) && !out_fifo_empty && credit_ok
                       && (rd_issued_q <= CNT_WIDTH'(job_q));

    assign busy    = busy_q;
    assign done    = done_q;
    assign wr_fifo = wr_fifo_q;
    assign din     = din_q;

    // Next-state and datapath
    always_comb begin
        state_d       = state_q;
        job_d         = job_q;
        in_cnt_d      = in_cnt_q;
        rd_issued_d   = rd_issued_q;
        out_cnt_d     = out_cnt_q;
        din_d         = din_q;
        wr_fifo_d     = 1'b0;
        rd_inflight_d = rd_fifo;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        occ_d         = occ_q;
        buf_d[0]      = buf_q[0];
        buf_d[1]      = buf_q[1];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    job_d       = m_minus_one;
                    in_cnt_d    = '0;
                    rd_issued_d = '0;
                    out_cnt_d   = '0;
                    wr_ptr_d    = 1'b0;
                    rd_ptr_d    = 1'b0;
                    occ_d       = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (s_hs) begin
                    din_d     = s_data;
                    wr_fifo_d = 1'b1;
                    in_cnt_d  = in_cnt_q + CNT_WIDTH'(1);
                    if (last_in) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (rd_fifo) begin
                    rd_issued_d = rd_issued_q + CNT_WIDTH'(1);
                end
                if (push) begin
                    buf_d[wr_ptr_q] = dout;
                    wr_ptr_d        = !wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_d  = !rd_ptr_q;
                    out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
                    if (last_out) begin
                        state_d = S_DONE;
                    end
                end
                occ_d = occ_q + OCC_WIDTH'(push) - OCC_WIDTH'(pop);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            job_q         <= '0;
            in_cnt_q      <= '0;
            rd_issued_q   <= '0;
            out_cnt_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wr_fifo_q     <= 1'b0;
            din_q         <= '0;
            rd_inflight_q <= 1'b0;
            buf_q[0]      <= '0;
            buf_q[1]      <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= '0;
        end else begin
            state_q       <= state_d;
            job_q         <= job_d;
            in_cnt_q      <= in_cnt_d;
            rd_issued_q   <= rd_issued_d;
            out_cnt_q     <= out_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            wr_fifo_q     <= wr_fifo_d;
            din_q         <= din_d;
            rd_inflight_q <= rd_inflight_d;
            buf_q[0]      <= buf_d[0];
            buf_q[1]      <= buf_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
        end
    end

endmodule

// File: tb/tb_sa_host_ctrl.sv
// Directed self-checking bench for sa_host_ctrl with simple input/output FIFO and sink models.
module tb_sa_host_ctrl;
    localparam int unsigned BUS_WIDTH = 64;

    logic                 sys_clk;
    logic                 rst;
    logic                 start;
    logic [7:0]           m_minus_one;
    logic                 busy;
    logic                 done;
    logic [BUS_WIDTH-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [BUS_WIDTH-1:0] din;
    logic                 wr_fifo;
    logic                 in_fifo_full;
    logic                 rd_fifo;
    logic [BUS_WIDTH-1:0] dout;
    logic                 out_fifo_empty;
    logic [BUS_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;

    int n_checks = 0;
    int n_errors = 0;
    int job_id   = 0;

    sa_host_ctrl #(.DIN_WIDTH(8), .N(4)) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .start          (start),
        .m_minus_one    (m_minus_one),
        .busy           (busy),
        .done           (done),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .din            (din),
        .wr_fifo        (wr_fifo),
        .in_fifo_full   (in_fifo_full),
        .rd_fifo        (rd_fifo),
        .dout           (dout),
        .out_fifo_empty (out_fifo_empty),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat_in(input int job, input int i);
        return {8'hA0, 8'(job), 16'h0000, 16'hBEEF, 16'(i)};
    endfunction

    function automatic logic [63:0] pat_out(input int job, input int i);
        return {8'hD0, 8'(job), 16'h0000, 16'hF00D, 16'(i)};
    endfunction

    task automatic check_outputs_zero(input string pfx);
        check_eq({pfx, "_busy"},    busy,    0);
        check_eq({pfx, "_done"},    done,    0);
        check_eq({pfx, "_s_ready"}, s_ready, 0);
        check_eq({pfx, "_wr_fifo"}, wr_fifo, 0);
        check_eq({pfx, "_rd_fifo"}, rd_fifo, 0);
        check_eq({pfx, "_m_valid"}, m_valid, 0);
        check_eq({pfx, "_din"},     din,     0);
        check_eq({pfx, "_m_data"},  m_data,  0);
    endtask

    // Runs one job from IDLE; entered and left at posedge+1.
    task automatic run_job(input logic [7:0] m1, input bit tog_full, input int stall_after,
                           input bit start_hold, input int empty_cycles, input bit chk_span);
        int m, cyc, rd_idx, stall_left;
        int hs_cnt, wr_cnt, rd_cnt, pop_cnt, done_cnt;
        int first_wr, last_wr, first_rd, last_rd;
        int full_viol, stab_viol, extra_ready, busy_low, rd_stall, rd_empty, max_out;
        bit finished, rd_pend, stall_used, prev_full, prev_mv, prev_mr;
        logic [63:0] prev_md;
        logic [63:0] wr_q[$];
        logic [63:0] out_q[$];

        m = int'(m1) + 1;
        job_id++;
        rd_idx = 0; stall_left = 0;
        hs_cnt = 0; wr_cnt = 0; rd_cnt = 0; pop_cnt = 0; done_cnt = 0;
        first_wr = -1; last_wr = -1; first_rd = -1; last_rd = -1;
        full_viol = 0; stab_viol = 0; extra_ready = 0; busy_low = 0;
        rd_stall = 0; rd_empty = 0; max_out = 0;
        finished = 0; rd_pend = 0; stall_used = 0;
        prev_full = 0; prev_mv = 0; prev_mr = 0; prev_md = '0;

        start = 1'b1; m_minus_one = m1; s_valid = 1'b0; m_ready = 1'b1;
        in_fifo_full = 1'b0; out_fifo_empty = 1'b0;
        @(posedge sys_clk); #1;
        start = start_hold;
        m_minus_one = start_hold ? ~m1 : m1;

        cyc = 0;
        while (!finished && cyc < 4 * m + 40) begin
            if (rd_pend) begin
                dout = pat_out(job_id, rd_idx);
                rd_idx++;
            end
            s_valid = (hs_cnt < m);
            s_data = pat_in(job_id, hs_cnt);
            in_fifo_full = tog_full && (cyc % 2 == 0);
            out_fifo_empty = (cyc < empty_cycles);
            if (!stall_used && stall_after >= 0 && pop_cnt == stall_after) begin
                stall_left = 3;
                stall_used = 1;
            end
            m_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;

            @(negedge sys_clk);
            if (!busy) busy_low++;
            if (wr_fifo) begin
                wr_q.push_back(din);
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (prev_full) full_viol++;
            end
            if (s_ready && hs_cnt >= m) extra_ready++;
            if (s_valid && s_ready) hs_cnt++;
            rd_pend = rd_fifo;
            if (rd_fifo) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (!m_ready) rd_stall++;
                if (out_fifo_empty) rd_empty++;
            end
            if (prev_mv && !prev_mr && (!m_valid || m_data !== prev_md)) stab_viol++;
            if (m_valid && m_ready) begin
                out_q.push_back(m_data);
                pop_cnt++;
            end
            if (rd_cnt - pop_cnt > max_out) max_out = rd_cnt - pop_cnt;
            prev_mv = m_valid; prev_mr = m_ready; prev_md = m_data; prev_full = in_fifo_full;
            if (done) begin
                done_cnt++;
                finished = 1;
            end
            @(posedge sys_clk); #1;
            cyc++;
        end

        start = 1'b0;
        s_valid = 1'b0;
        check_eq("job_finished", finished, 1);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_done", done, 0);
        check_eq("wr_count", wr_cnt, m);
        check_eq("rd_count", rd_cnt, m);
        check_eq("pop_count", pop_cnt, m);
        check_eq("done_count", done_cnt, 1);
        check_eq("wr_after_full", full_viol, 0);
        check_eq("m_stability", stab_viol, 0);
        check_eq("s_ready_after_last", extra_ready, 0);
        check_eq("busy_during_job", busy_low, 0);
        check_eq("rd_while_stalled", rd_stall, 0);
        check_eq("rd_while_empty", rd_empty, 0);
        check_eq("max_outstanding", max_out, (m >= 2) ? 2 : 1);
        if (chk_span) begin
            check_eq("wr_span", last_wr - first_wr + 1, m);
            check_eq("rd_span", last_rd - first_rd + 1, m);
        end
        for (int i = 0; i < m; i++) begin
            if (i < wr_q.size()) check_eq("wr_data", wr_q[i], pat_in(job_id, i));
            if (i < out_q.size()) check_eq("out_data", out_q[i], pat_out(job_id, i));
        end
        @(posedge sys_clk); #1;
        check_eq("idle_stays_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; m_minus_one = '0; s_valid = 1'b0; s_data = '0;
        in_fifo_full = 1'b0; out_fifo_empty = 1'b1; dout = '0; m_ready = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge sys_clk); #1;

        // Abort a job mid-LOAD with an asynchronous reset
        start = 1'b1; m_minus_one = 8'd3;
        @(posedge sys_clk); #1;
        start = 1'b0; s_valid = 1'b1; s_data = pat_in(99, 0);
        @(posedge sys_clk); #1;
        s_data = pat_in(99, 1);
        @(posedge sys_clk); #1;
        check_eq("pre_rst_busy", busy, 1);
        check_eq("pre_rst_wr_fifo", wr_fifo, 1);
        #3 rst = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        @(posedge sys_clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        @(posedge sys_clk); #1;

        run_job(8'd3,   1'b0, -1, 1'b0, 0, 1'b1);
        run_job(8'd3,   1'b1, -1, 1'b0, 0, 1'b0);
        run_job(8'd7,   1'b0, -1, 1'b0, 0, 1'b1);
        run_job(8'd7,   1'b0,  2, 1'b0, 0, 1'b0);
        run_job(8'd255, 1'b0, -1, 1'b1, 0, 1'b1);
        run_job(8'd0,   1'b0, -1, 1'b1, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
